xfer_base_station: RTL and testbench
====================================

# xfer_base_station

Ground-side receiving end of the scanner transfer protocol. It watches both scanners' `rdy_xfer`/`state`/`mem_used` outputs and grants a transfer to one scanner at a time by driving that scanner's `xfer` input. It then counts the data units drained from the scanner's memory into a local receive buffer, and it releases buffered units to a downstream consumer one per cycle.

## Interface
- `BUF_CAP`, default 255: receive buffer capacity in units; legal range 100..511.
- `TIMEOUT`, default 200: cycles allowed in GRANT before the grant is abandoned; legal range 1..1023.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rdy_xfer1` in 1: scanner 1 ready to transfer.
- `rdy_xfer2` in 1: scanner 2 ready to transfer.
- `mem_used1` in 8: scanner 1 memory occupancy.
- `mem_used2` in 8: scanner 2 memory occupancy.
- `state1` in 3: scanner 1 state; 3'b101 = xferring.
- `state2` in 3: scanner 2 state.
- `rd_en` in 1: downstream takes one unit this cycle.
- `xfer1` out 1: transfer grant to scanner 1, level.
- `xfer2` out 1: transfer grant to scanner 2, level.
- `buf_used` out 9: units held in the receive buffer.
- `rd_valid` out 1: `buf_used != 0`, combinational.
- `xfer_done` out 1: one-cycle pulse when a transfer completes.
- `timeout_err` out 1: one-cycle pulse when a grant is abandoned.
- `ovf` out 1: sticky; set when received data was clipped at `BUF_CAP`.
- `xfer_count` out 8: number of completed transfers, wraps 255→0.
- `bs_state` out 2: current FSM state.

## Operation
- FSM states are IDLE=0, GRANT=1, RECV=2, DONE=3. The register `sel` records the active scanner; `last` records the scanner served last.
- IDLE, eligibility: scanner N is eligible when `rdy_xferN` is high and `BUF_CAP - buf_used >= mem_usedN`.
- IDLE, selection: pick among eligible scanners by the arbitration rule in Configuration. On a pick, load `sel`, clear the timeout counter, and go to GRANT.
- GRANT: assert `xfer[sel]`.
  - If `state[sel] == 3'b101`: latch `prev <= mem_used[sel]` and go to RECV.
  - Otherwise, if the timeout counter reaches `TIMEOUT-1`: pulse `timeout_err` and go to IDLE; `last` is not updated.
  - Otherwise, increment the timeout counter.
- RECV: keep `xfer[sel]` asserted.
  - Each cycle, `delta = prev - mem_used[sel]` when `mem_used[sel] < prev`, else 0. Then `prev <= mem_used[sel]`.
  - When `state[sel] != 3'b101`, the transfer has ended; go to DONE. The delta in the exit cycle is still credited.
- DONE: deassert both `xfer` outputs, pulse `xfer_done`, increment `xfer_count`, set `last <= sel`, and go to IDLE.
- Buffer update, every cycle: `buf_used <= buf_used + delta - (rd_en & rd_valid)`.
  - If the result exceeds `BUF_CAP`, clamp it to `BUF_CAP` and set `ovf`.
  - `rd_en` when `buf_used == 0` is ignored.
  - A simultaneous credit and drain is netted within the same cycle.
- At most one `xfer` output is high at any time. Both are low in IDLE and DONE.

## Timing
- Reset values: state IDLE; `xfer1`, `xfer2`, `xfer_done`, `timeout_err`, `ovf` all 0; `buf_used` 0; `xfer_count` 0; `last` = scanner 2, so scanner 1 wins the first tie; timeout counter and `prev` 0.
- All outputs except `rd_valid` are registered.
- Grant latency: `rdy_xfer` sampled in IDLE at edge k produces `xfer` high after edge k+1.
- Credit latency: a `mem_used` decrement seen at edge k appears in `buf_used` after edge k+1.
- `xfer_done` is high for exactly one cycle, in the cycle after RECV is exited. The next grant can be issued at the earliest one cycle after that.
- A reset asserted mid-transfer returns the block to IDLE on the next edge and drops `xfer` immediately. Units credited before the reset are lost.

## Configuration
- `BASE_ROUND_ROBIN_EN` defined: on a tie, grant the scanner that is not `last`.
- `BASE_ROUND_ROBIN_EN` undefined: fixed priority, scanner 1 always wins a tie; `last` is still maintained but is not used for arbitration.

## Test plan
- Scanner 1 raises `rdy_xfer1` with `mem_used1`=100, enters state 5 two cycles after `xfer1`, then drains 1 per cycle to 0 → `buf_used`=100, one `xfer_done` pulse, `xfer_count`=1, `xfer1` low in DONE.
- Both scanners ready at 90; `BASE_ROUND_ROBIN_EN` defined → grant order 1, 2, 1 over three rounds. With the macro undefined → 1, 1, 1.
- `xfer1` granted but `state1` never reaches 5, `TIMEOUT`=200 → `timeout_err` pulses 200 cycles after entry to GRANT, FSM returns to IDLE, `xfer_count` is unchanged.
- `buf_used`=200, `BUF_CAP`=255, scanner 1 ready with 80 → no grant until `rd_en` drains `buf_used` to 175 or below. Separately, force a scanner to deliver 60 units into 200 → `buf_used`=255 and `ovf`=1.
- `rd_en` held high during RECV while receiving 1 unit per cycle → `buf_used` stays constant; with `buf_used`=0 and `rd_en`=1, nothing changes.
- `reset` asserted in RECV with `buf_used`=40 → next cycle all outputs are at reset values and `xfer1`=0.

Source files
------------

// File: rtl/xfer_base_station.sv
// Purpose: ground-side receiver; grants one scanner at a time, counts drained units into a receive buffer, releases them downstream.
// Latency: grant one edge after eligibility is seen in IDLE; a scanner mem_used decrement lands in buf_used on the next edge.
// Backpressure: a scanner is granted only when its mem_used fits the free buffer space; rd_en drains one unit per cycle while rd_valid.
// Option: define BASE_ROUND_ROBIN_EN for round-robin tie-break between scanners; undefined gives fixed priority to scanner 1.

module xfer_base_station #(
    parameter int BUF_CAP = 255,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy_xfer1,
    input  logic       rdy_xfer2,
    input  logic [7:0] mem_used1,
    input  logic [7:0] mem_used2,
    input  logic [2:0] state1,
    input  logic [2:0] state2,
    input  logic       rd_en,
    output logic       xfer1,
    output logic       xfer2,
    output logic [8:0] buf_used,
    output logic       rd_valid,
    output logic       xfer_done,
    output logic       timeout_err,
    output logic       ovf,
    output logic [7:0] xfer_count,
    output logic [1:0] bs_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] ST_XFERRING = 3'b101;
    localparam logic [9:0] CAP         = 10'(BUF_CAP);
    localparam logic [9:0] TO_LAST     = 10'(TIMEOUT - 1);

    // sel/last encoding: 0 = scanner 1, 1 = scanner 2
    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [9:0] tcnt_q, tcnt_d;
    logic [7:0] prev_q, prev_d;
    logic [8:0] buf_q, buf_d;
    logic       ovf_q, ovf_d;
    logic       done_q, done_d;
    logic       terr_q, terr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       xfer1_q, xfer1_d;
    logic       xfer2_q, xfer2_d;

    logic [7:0] mem_sel;
    logic [2:0] st_sel;
    logic [9:0] room;
    logic       elig1, elig2;
    logic       pick;
    logic [7:0] delta;
    logic       drain;
    logic [9:0] sum;

    assign mem_sel = sel_q ? mem_used2 : mem_used1;
    assign st_sel  = sel_q ? state2 : state1;
    assign room    = CAP - {1'b0, buf_q};
    assign elig1   = rdy_xfer1 && (room >= {2'b00, mem_used1});
    assign elig2   = rdy_xfer2 && (room >= {2'b00, mem_used2});

`ifdef BASE_ROUND_ROBIN_EN
    // On a tie serve whichever scanner was not served last
    assign pick = (elig1 && elig2) ? ~last_q : elig2;
`else
    // Scanner 1 wins every tie
    assign pick = elig2 && !elig1;
`endif

    // Next-state logic: arbitration, grant timeout, credit extraction, completion bookkeeping
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        prev_d  = prev_q;
        terr_d  = 1'b0;
        delta   = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (elig1 || elig2) begin
                    sel_d   = pick;
                    tcnt_d  = 10'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (st_sel == ST_XFERRING) begin
                    prev_d  = mem_sel;
                    state_d = RECV;
                end else if (tcnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 10'd1;
                end
            end
            RECV: begin
                // the exit cycle's decrement is still credited
                if (mem_sel < prev_q) begin
                    delta = prev_q - mem_sel;
                end
                prev_d = mem_sel;
                if (st_sel != ST_XFERRING) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so xfer drops on the edge entering DONE
        xfer1_d = ((state_d == GRANT) || (state_d == RECV)) && !sel_d;
        xfer2_d = ((state_d == GRANT) || (state_d == RECV)) && sel_d;
        done_d  = (state_d == DONE);
        cnt_d   = cnt_q;
        if (state_d == DONE) begin
            cnt_d  = cnt_q + 8'd1;
            last_d = sel_q;
        end
    end

    // Buffer occupancy: net credit and drain in one step, clamp at capacity and flag the clip
    always_comb begin
        drain = rd_en && (buf_q != 9'd0);
        sum   = {1'b0, buf_q} + {2'b00, delta} - {9'd0, drain};
        buf_d = sum[8:0];
        ovf_d = ovf_q;
        if (sum > CAP) begin
            buf_d = CAP[8:0];
            ovf_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset; last starts at scanner 2 so scanner 1 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= 10'd0;
            prev_q  <= 8'd0;
            buf_q   <= 9'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= 8'd0;
            xfer1_q <= 1'b0;
            xfer2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            prev_q  <= prev_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
            xfer1_q <= xfer1_d;
            xfer2_q <= xfer2_d;
        end
    end

    assign xfer1       = xfer1_q;
    assign xfer2       = xfer2_q;
    assign buf_used    = buf_q;
    assign rd_valid    = (buf_q != 9'd0);
    assign xfer_done   = done_q;
    assign timeout_err = terr_q;
    assign ovf         = ovf_q;
    assign xfer_count  = cnt_q;
    assign bs_state    = state_q;

endmodule

// File: tb/tb_xfer_base_station.sv
// Bench for xfer_base_station: scripted scanners, scoreboard of expected transfer completions.
// Inputs are driven 1 time unit after the rising edge; the completion monitor samples on the falling edge.
// Build with BASE_ROUND_ROBIN_EN defined to expect round-robin arbitration order.

module tb_xfer_base_station;

    localparam int BUF_CAP = 255;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       rdy_xfer1, rdy_xfer2;
    logic [7:0] mem_used1, mem_used2;
    logic [2:0] state1, state2;
    logic       rd_en;
    logic       xfer1, xfer2;
    logic [8:0] buf_used;
    logic       rd_valid, xfer_done, timeout_err, ovf;
    logic [7:0] xfer_count;
    logic [1:0] bs_state;

    always #5 clk = ~clk;

    xfer_base_station #(.BUF_CAP(BUF_CAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .rdy_xfer1(rdy_xfer1), .rdy_xfer2(rdy_xfer2),
        .mem_used1(mem_used1), .mem_used2(mem_used2),
        .state1(state1), .state2(state2),
        .rd_en(rd_en),
        .xfer1(xfer1), .xfer2(xfer2),
        .buf_used(buf_used), .rd_valid(rd_valid),
        .xfer_done(xfer_done), .timeout_err(timeout_err),
        .ovf(ovf), .xfer_count(xfer_count), .bs_state(bs_state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int sc;
        int buf_v;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   exp_buf;
    int   exp_cnt;
    int   cur_sc = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input int s, input logic v);
        if (s == 1) rdy_xfer1 = v;
        else if (s == 2) rdy_xfer2 = v;
    endtask

    task automatic set_mem(input int s, input int v);
        if (s == 1) mem_used1 = 8'(v);
        else if (s == 2) mem_used2 = 8'(v);
    endtask

    task automatic set_st(input int s, input int v);
        if (s == 1) state1 = 3'(v);
        else if (s == 2) state2 = 3'(v);
    endtask

    task automatic check_reset_values;
        check("rst_state", bs_state, 0);
        check("rst_xfer1", xfer1, 0);
        check("rst_xfer2", xfer2, 0);
        check("rst_buf", buf_used, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", xfer_done, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_count", xfer_count, 0);
    endtask

    // Bounded wait for either grant; lat counts edges until a grant is seen
    task automatic wait_grant(output int who, output int lat);
        who = 0;
        lat = 0;
        while (who == 0 && lat < 20) begin
            tick;
            lat++;
            if (xfer1) who = 1;
            else if (xfer2) who = 2;
        end
        if (who == 0) check("grant_wait_expired", 0, 1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick;
            exp_buf--;
        end
        rd_en = 1'b0;
        check("drain_buf", buf_used, exp_buf);
    endtask

    // Scanner s (already granted) waits two cycles, enters xferring, drains one unit per cycle.
    // rd: downstream reads alongside every credit; drop_last: leave xferring on the final decrement.
    task automatic run_scan(input int s, input int exp_s, input int units, input bit rd, input bit drop_last);
        int   nb;
        exp_t e;
        nb = rd ? exp_buf : ((exp_buf + units > BUF_CAP) ? BUF_CAP : exp_buf + units);
        exp_cnt++;
        e.sc = exp_s;
        e.buf_v = nb;
        e.cnt = exp_cnt & 255;
        sb.push_back(e);
        repeat (2) tick;
        set_st(s, 5);
        set_mem(s, units);
        set_rdy(s, 1'b0);
        tick;
        check("recv_entry", bs_state, 2);
        for (int i = units - 1; i >= 0; i--) begin
            set_mem(s, i);
            rd_en = rd;
            if (i == 0 && drop_last) set_st(s, 0);
            tick;
            if (rd) check("rd_net_const", buf_used, exp_buf);
            else if (i == units - 1) check("credit_latency", buf_used, exp_buf + 1);
        end
        rd_en = 1'b0;
        if (!drop_last) begin
            set_st(s, 0);
            tick;
        end
        check("done_state", bs_state, 3);
        exp_buf = nb;
    endtask

    // Completion monitor: exclusivity every cycle, scoreboard pop on each xfer_done
    always @(negedge clk) begin
        if (!reset) begin
            check("xfer_exclusive", int'(xfer1 & xfer2), 0);
            if (xfer1) cur_sc = 1;
            else if (xfer2) cur_sc = 2;
            if (xfer_done) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_scanner", cur_sc, e.sc);
                    check("done_buf", buf_used, e.buf_v);
                    check("done_count", xfer_count, e.cnt);
                    check("done_xfer_low", int'(xfer1 | xfer2), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int who, lat, n, exp_s;
        reset = 1'b1;
        rdy_xfer1 = 1'b0; rdy_xfer2 = 1'b0;
        mem_used1 = 8'd0; mem_used2 = 8'd0;
        state1 = 3'd0; state2 = 3'd0;
        rd_en = 1'b0;
        repeat (3) tick;
        check_reset_values;
        reset = 1'b0;
        exp_buf = 0;
        exp_cnt = 0;

        // Basic transfer of 100 units from scanner 1
        set_mem(1, 100);
        set_rdy(1, 1'b1);
        wait_grant(who, lat);
        check("t1_who", who, 1);
        check("t1_grant_lat", lat, 1);
        check("t1_state_grant", bs_state, 1);
        run_scan(1, 1, 100, 1'b0, 1'b0);
        tick;
        check("t1_done_width", xfer_done, 0);
        check("t1_idle", bs_state, 0);
        check("t1_buf", buf_used, 100);
        check("t1_count", xfer_count, 1);

        // Arbitration over three tied rounds from reset
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_buf = 0;
        exp_cnt = 0;
        for (int r = 0; r < 3; r++) begin
`ifdef BASE_ROUND_ROBIN_EN
            exp_s = (r % 2 == 0) ? 1 : 2;
`else
            exp_s = 1;
`endif
            set_mem(1, 90); set_mem(2, 90);
            set_rdy(1, 1'b1); set_rdy(2, 1'b1);
            wait_grant(who, lat);
            check("arb_order", who, exp_s);
            run_scan(who, exp_s, 90, 1'b0, r == 1);
            set_rdy(1, 1'b0); set_rdy(2, 1'b0);
            tick;
            drain(90);
        end

        // Grant abandoned when the scanner never enters xferring
        set_mem(1, 10);
        set_rdy(1, 1'b1);
        wait_grant(who, lat);
        check("to_who", who, 1);
        n = 0;
        while (!timeout_err && n < 300) begin
            tick;
            n++;
        end
        set_rdy(1, 1'b0);
        check("to_cycles", n, TIMEOUT);
        check("to_idle", bs_state, 0);
        check("to_xfer_low", xfer1, 0);
        check("to_count", xfer_count, exp_cnt);
        tick;
        check("to_pulse_width", timeout_err, 0);

        // Eligibility against free space, exact fill, then clipped overflow
        set_mem(1, 200);
        set_rdy(1, 1'b1);
        wait_grant(who, lat);
        run_scan(1, 1, 200, 1'b0, 1'b1);
        tick;
        check("el_buf200", buf_used, 200);
        set_mem(1, 80);
        set_rdy(1, 1'b1);
        repeat (4) tick;
        check("el_block_state", bs_state, 0);
        check("el_block_xfer", xfer1, 0);
        drain(24);
        check("el_176_idle", bs_state, 0);
        drain(1);
        check("el_175_idle", bs_state, 0);
        wait_grant(who, lat);
        check("el_who", who, 1);
        check("el_grant_lat", lat, 1);
        run_scan(1, 1, 80, 1'b0, 1'b0);
        tick;
        check("cap_exact_buf", buf_used, 255);
        check("cap_exact_ovf", ovf, 0);
        drain(55);
        set_mem(2, 10);
        set_rdy(2, 1'b1);
        wait_grant(who, lat);
        check("ovf_who", who, 2);
        run_scan(2, 2, 60, 1'b0, 1'b0);
        tick;
        check("ovf_buf", buf_used, 255);
        check("ovf_set", ovf, 1);
        tick;
        check("ovf_sticky", ovf, 1);

        // Reads netted against credits during RECV; reads on an empty buffer ignored
        drain(205);
        set_mem(1, 20);
        set_rdy(1, 1'b1);
        wait_grant(who, lat);
        run_scan(1, 1, 20, 1'b1, 1'b0);
        tick;
        check("rd_buf_after", buf_used, 50);
        drain(50);
        rd_en = 1'b1;
        repeat (3) tick;
        check("rd_empty_buf", buf_used, 0);
        check("rd_empty_valid", rd_valid, 0);
        rd_en = 1'b0;

        // Reset while receiving with 40 units credited
        set_mem(1, 60);
        set_rdy(1, 1'b1);
        wait_grant(who, lat);
        repeat (2) tick;
        set_st(1, 5);
        set_rdy(1, 1'b0);
        tick;
        for (int i = 59; i >= 20; i--) begin
            set_mem(1, i);
            tick;
        end
        check("mid_buf40", buf_used, 40);
        check("mid_recv", bs_state, 2);
        check("mid_xfer1", xfer1, 1);
        reset = 1'b1;
        tick;
        check_reset_values;
        reset = 1'b0;
        set_st(1, 0);
        set_mem(1, 0);
        tick;
        check("post_rst_idle", bs_state, 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
